// File: rtl/rr_hold_ctrl_scan.sv
// Round-robin grant sequencer over NCH channels with a per-grant hold timeout and a full scan chain.
// Latency: request in IDLE -> grant on the next CK edge; outputs decode straight from flops.
// Backpressure: none; a grant is held while its request stays high, up to MAX_HOLD cycles.
module rr_hold_ctrl_scan #(
    parameter int NCH      = 4,
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           SE,
    input  logic           SI,
    output logic           SO,
    input  logic [NCH-1:0] REQ,
    output logic [NCH-1:0] GNT,
    output logic           BUSY,
    output logic           ERR
);
    localparam int PTR_W = $clog2(NCH);
    localparam int NPAD  = 1 << PTR_W;
    localparam int L     = 2 + PTR_W + HOLD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_REL   = 2'b10,
        ST_ERR   = 2'b11
    } st_e;

    st_e               st_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [HOLD_W-1:0] cnt_q;

    logic [NPAD-1:0]   req_pad;
    logic [PTR_W-1:0]  arb_ptr_d;
    logic [PTR_W-1:0]  idx;
    int                start_i;
    logic [L-1:0]      chain_d;

    // Padding REQ to 2**PTR_W makes an out-of-range loaded ptr read as "no request".
    always_comb begin
        req_pad          = '0;
        req_pad[NCH-1:0] = REQ;
        start_i          = (int'(ptr_q) >= NCH - 1) ? 0 : int'(ptr_q) + 1;
        arb_ptr_d        = ptr_q;
        idx              = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = PTR_W'((start_i + k) % NCH);
            if (req_pad[idx]) begin
                arb_ptr_d = idx;
            end
        end
    end

    // Chain order SI -> st[0] -> st[1] -> ptr[0..] -> cnt[0..] -> SO.
    assign chain_d = {cnt_q[HOLD_W-2:0], ptr_q, st_q, SI};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            st_q  <= ST_IDLE;
            ptr_q <= PTR_W'(NCH - 1);
            cnt_q <= '0;
        end else if (SE) begin
            st_q  <= st_e'(chain_d[1:0]);
            ptr_q <= chain_d[2 +: PTR_W];
            cnt_q <= chain_d[2 + PTR_W +: HOLD_W];
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (|REQ) begin
                        st_q  <= ST_GRANT;
                        ptr_q <= arb_ptr_d;
                        cnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!req_pad[ptr_q]) begin
                        st_q <= ST_REL;
                    end else if (cnt_q >= HOLD_W'(MAX_HOLD - 1)) begin
                        st_q <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_REL: begin
                    st_q  <= ST_IDLE;
                    cnt_q <= '0;
                end
                ST_ERR: begin
                    if (!(|REQ)) begin
                        st_q  <= ST_IDLE;
                        cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        GNT = '0;
        for (int i = 0; i < NCH; i++) begin
            GNT[i] = (st_q == ST_GRANT) && (ptr_q == PTR_W'(i));
        end
    end

    assign BUSY = (st_q != ST_IDLE);
    assign ERR  = (st_q == ST_ERR);
    assign SO   = cnt_q[HOLD_W-1];

endmodule

// File: tb/tb_rr_hold_ctrl_scan.sv
// Bench for rr_hold_ctrl_scan: NCH=4 instance tracked by a behavioural model every cycle,
// plus an NCH=3 instance for the out-of-range pointer case.
module tb_rr_hold_ctrl_scan;
    localparam int NCH      = 4;
    localparam int MAX_HOLD = 8;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       SE = 1'b0;
    logic       SI = 1'b0;
    logic [3:0] REQ = 4'b1111;
    logic [3:0] GNT;
    logic       BUSY, ERR, SO;

    logic       SE3 = 1'b0;
    logic       SI3 = 1'b0;
    logic [2:0] REQ3 = 3'b000;
    logic [2:0] GNT3;
    logic       BUSY3, ERR3, SO3;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 CK = ~CK;

    rr_hold_ctrl_scan #(.NCH(4), .HOLD_W(4), .MAX_HOLD(8)) dut (
        .CK(CK), .RN(RN), .SE(SE), .SI(SI), .SO(SO),
        .REQ(REQ), .GNT(GNT), .BUSY(BUSY), .ERR(ERR)
    );

    rr_hold_ctrl_scan #(.NCH(3), .HOLD_W(4), .MAX_HOLD(8)) dut3 (
        .CK(CK), .RN(RN), .SE(SE3), .SI(SI3), .SO(SO3),
        .REQ(REQ3), .GNT(GNT3), .BUSY(BUSY3), .ERR(ERR3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Behavioural model: state as plain integers (0 idle, 1 grant, 2 release, 3 error).
    int m_st  = 0;
    int m_ptr = NCH - 1;
    int m_cnt = 0;
    int mv;
    bit found;

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_st  = 0;
            m_ptr = NCH - 1;
            m_cnt = 0;
        end else if (SE) begin
            mv    = m_st + m_ptr * 4 + m_cnt * 16;
            mv    = (mv * 2 + int'(SI)) % 256;
            m_st  = mv % 4;
            m_ptr = (mv / 4) % 4;
            m_cnt = mv / 16;
        end else begin
            case (m_st)
                0: if (REQ != 4'b0000) begin
                    found = 1'b0;
                    for (int j = 1; j <= NCH; j++) begin
                        if (!found && (((int'(REQ) >> ((m_ptr + j) % NCH)) & 1) == 1)) begin
                            found = 1'b1;
                            m_ptr = (m_ptr + j) % NCH;
                        end
                    end
                    m_st  = 1;
                    m_cnt = 0;
                end
                1: if (((int'(REQ) >> m_ptr) & 1) == 0) m_st = 2;
                   else if (m_cnt >= MAX_HOLD - 1) m_st = 3;
                   else m_cnt = m_cnt + 1;
                2: begin m_st = 0; m_cnt = 0; end
                default: if (REQ == 4'b0000) begin m_st = 0; m_cnt = 0; end
            endcase
        end
    end

    always @(negedge CK) begin
        if (cmp_en) begin
            chk("model_gnt",  int'(GNT),  (m_st == 1) ? (1 << m_ptr) : 0);
            chk("model_busy", int'(BUSY), (m_st != 0) ? 1 : 0);
            chk("model_err",  int'(ERR),  (m_st == 3) ? 1 : 0);
            chk("model_so",   int'(SO),   (m_cnt >> 3) & 1);
        end
    end

    logic [3:0] exp_seq [0:4];
    logic [7:0] scan_v;
    logic [7:0] scan_out;
    int         hold_cycles;

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

        // Reset state with all requests high
        #2 cmp_en = 1'b1;
        #1;
        chk("rst_gnt",  int'(GNT),  0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_so",   int'(SO),   0);
        tick();
        RN = 1'b1;
        tick();
        chk("first_gnt", int'(GNT), 4'b0001);

        // Round robin with a release gap between grants
        for (int g = 0; g < 4; g++) begin
            tick();
            REQ = 4'b1111 & ~exp_seq[g];
            tick();
            chk("rr_gap", int'(GNT), 0);
            REQ = 4'b1111;
            tick();
            tick();
            chk("rr_gnt", int'(GNT), int'(exp_seq[g + 1]));
        end

        // Hold timeout on channel 2
        REQ = 4'b0000;
        tick();
        tick();
        REQ = 4'b0100;
        tick();
        hold_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (GNT == 4'b0100) begin
                hold_cycles++;
                tick();
            end
        end
        chk("hold_len", hold_cycles, 8);
        chk("to_err",   int'(ERR),  1);
        chk("to_gnt",   int'(GNT),  0);
        REQ = 4'b0000;
        tick();
        chk("err_clr",  int'(ERR),  0);
        chk("err_idle", int'(BUSY), 0);
        REQ = 4'b0101;
        tick();
        chk("after_to_gnt", int'(GNT), 4'b0001);

        // Scan load GRANT/ptr=3/cnt=5, run to timeout, unload
        REQ = 4'b0000;
        tick();
        tick();
        REQ    = 4'b1000;
        scan_v = 8'b0101_1101;
        SE     = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            SI = scan_v[i];
            tick();
        end
        chk("scan_gnt",  int'(GNT),  4'b1000);
        chk("scan_busy", int'(BUSY), 1);
        SE = 1'b0;
        SI = 1'b0;
        tick();
        tick();
        chk("scan_run_err0", int'(ERR), 0);
        tick();
        chk("scan_run_err1", int'(ERR), 1);
        SE = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            scan_out[i] = SO;
            tick();
        end
        chk("scan_unload", int'(scan_out), 8'h7F);
        REQ = 4'b0000;
        SE  = 1'b0;
        tick();

        // Asynchronous reset in the middle of a grant (cnt=4)
        REQ = 4'b0010;
        tick();
        chk("pre_rst_gnt", int'(GNT), 4'b0010);
        repeat (4) tick();
        #2 RN = 1'b0;
        #1;
        chk("async_gnt",  int'(GNT),  0);
        chk("async_busy", int'(BUSY), 0);
        tick();
        REQ = 4'b1111;
        RN  = 1'b1;
        tick();
        chk("post_rst_gnt", int'(GNT), 4'b0001);
        REQ = 4'b0000;
        tick();
        tick();

        // NCH=3: loaded ptr=3 in GRANT
        scan_v = 8'b0000_1101;
        SE3    = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            SI3 = scan_v[i];
            tick();
        end
        chk("n3_gnt",  int'(GNT3),  0);
        chk("n3_busy", int'(BUSY3), 1);
        chk("n3_err",  int'(ERR3),  0);
        SE3 = 1'b0;
        SI3 = 1'b0;
        tick();
        chk("n3_rel_busy", int'(BUSY3), 1);
        chk("n3_rel_gnt",  int'(GNT3),  0);
        tick();
        chk("n3_idle", int'(BUSY3), 0);
        REQ3 = 3'b101;
        tick();
        chk("n3_search_from0", int'(GNT3), 3'b001);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
